// File: rtl/imm_generator.sv
// RV32I immediate extraction: decodes the format from the opcode and registers
// the sign-extended (or shifted) 32-bit immediate with one cycle of latency.
module imm_generator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [31:0] immOut,
  output logic [2:0]  immType,
  output logic        immValid
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  imm_fmt_e    fmt;
  logic [31:0] imm_d;
  logic        sign;

  assign sign = instruction[31];

  always_comb begin
    fmt = FMT_NONE;
    case (instruction[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt = FMT_I;
      OP_STORE:                            fmt = FMT_S;
      OP_BRANCH:                           fmt = FMT_B;
      OP_LUI, OP_AUIPC:                    fmt = FMT_U;
      OP_JAL:                              fmt = FMT_J;
      default:                             fmt = FMT_NONE;
    endcase
  end

  // Each format touches only its own fields so X on unused bits cannot leak.
  always_comb begin
    imm_d = '0;
    case (fmt)
      FMT_I: imm_d = {{20{sign}}, instruction[31:20]};
      FMT_S: imm_d = {{20{sign}}, instruction[31:25], instruction[11:7]};
      FMT_B: imm_d = {{19{sign}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
      FMT_U: imm_d = {instruction[31:12], 12'b0};
      FMT_J: imm_d = {{11{sign}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
      default: imm_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      immOut   <= '0;
      immType  <= FMT_NONE;
      immValid <= 1'b0;
    end else begin
      immOut   <= imm_d;
      immType  <= fmt;
      immValid <= (fmt != FMT_NONE);
    end
  end

endmodule

// File: tb/tb_imm_generator.sv
// Directed bench for imm_generator: arithmetic reference model checked every
// cycle, plus literal expectations on the hand-computed vectors.
`timescale 1ns/1ps
module tb_imm_generator;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] immOut;
  logic [2:0]  immType;
  logic        immValid;

  int checks   = 0;
  int failures = 0;

  imm_generator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .immOut      (immOut),
    .immType     (immType),
    .immValid    (immValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] model_type(input logic [31:0] i);
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: return 3'd1;
      7'b0100011:                                     return 3'd2;
      7'b1100011:                                     return 3'd3;
      7'b0110111, 7'b0010111:                         return 3'd4;
      7'b1101111:                                     return 3'd5;
      default:                                        return 3'd0;
    endcase
  endfunction

  // Immediate as a signed integer: weighted field sums, MSB carries negative weight.
  function automatic logic [31:0] model_imm(input logic [31:0] i);
    int v;
    v = 0;
    case (model_type(i))
      3'd1: v = int'(i[30:20]) - (i[31] ? 2048 : 0);
      3'd2: v = int'(i[30:25]) * 32 + int'(i[11:7]) - (i[31] ? 2048 : 0);
      3'd3: v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2
                - (i[31] ? 4096 : 0);
      3'd4: return i & 32'hFFFF_F000;
      3'd5: v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2
                - (i[31] ? 1048576 : 0);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // Per-cycle model comparison; inputs change only on negedge so sampling here is stable.
  logic [31:0] e_imm;
  logic [2:0]  e_type;
  logic        e_valid;
  bit          primed = 0;

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      e_imm   = model_imm(instruction);
      e_type  = model_type(instruction);
      e_valid = (e_type != 3'd0);
    end else begin
      e_imm   = '0;
      e_type  = '0;
      e_valid = 1'b0;
    end
    primed = 1;
    #2;
    if (primed) begin
      checks++;
      if (immOut !== e_imm || immType !== e_type || immValid !== e_valid) begin
        failures++;
        $display("FAIL model t=%0t got imm=%h type=%0d valid=%b want imm=%h type=%0d valid=%b",
                 $time, immOut, immType, immValid, e_imm, e_type, e_valid);
      end
    end
  end

  task automatic run(input logic [31:0] instr, input logic rst,
                     input logic [31:0] x_imm, input logic [2:0] x_type,
                     input logic x_valid, input string name);
    @(negedge clk);
    instruction = instr;
    rst_n       = rst;
    @(posedge clk);
    #3;
    checks++;
    if (immOut !== x_imm || immType !== x_type || immValid !== x_valid) begin
      failures++;
      $display("FAIL %s got imm=%h type=%0d valid=%b want imm=%h type=%0d valid=%b",
               name, immOut, immType, immValid, x_imm, x_type, x_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] s_instr;
    logic [31:0] b_instr;
    logic [31:0] i_instr;
    s_instr = {7'b0000110, 13'bx, 5'b00011, 7'b0100011};
    b_instr = {7'b0000000, 13'bx, 5'b00010, 7'b1100011};
    i_instr = {12'h00C, 13'bx, 7'b0010011};
    rst_n = 1'b0;
    instruction = 32'hFFF0_0013;

    run(32'hFFF0_0013, 1'b0, 32'h0, 3'd0, 1'b0, "reset_1");
    run(32'hFFF0_0013, 1'b0, 32'h0, 3'd0, 1'b0, "reset_2");

    run(i_instr,       1'b1, 32'h0000_000C, 3'd1, 1'b1, "itype_pos");
    run(32'hFFF0_0013, 1'b1, 32'hFFFF_FFFF, 3'd1, 1'b1, "itype_neg");
    run(32'h8000_0003, 1'b1, 32'hFFFF_F800, 3'd1, 1'b1, "load_min");
    run(32'h0040_8067, 1'b1, 32'h0000_0004, 3'd1, 1'b1, "jalr");
    run(32'h3410_2073, 1'b1, 32'h0000_0341, 3'd1, 1'b1, "system");

    run(s_instr,       1'b1, 32'h0000_00C3, 3'd2, 1'b1, "stype");
    run(s_instr,       1'b1, 32'h0000_00C3, 3'd2, 1'b1, "stype_hold");
    run(32'hFE00_0FA3, 1'b1, 32'hFFFF_FFFF, 3'd2, 1'b1, "stype_neg");

    run(b_instr,       1'b1, 32'h0000_0002, 3'd3, 1'b1, "btype");
    run(32'hFE00_0FE3, 1'b1, 32'hFFFF_FFFE, 3'd3, 1'b1, "btype_neg");
    run(32'h0000_00E3, 1'b1, 32'h0000_0800, 3'd3, 1'b1, "btype_b11");

    run(32'h1234_50B7, 1'b1, 32'h1234_5000, 3'd4, 1'b1, "lui");
    run(32'hFFFF_F097, 1'b1, 32'hFFFF_F000, 3'd4, 1'b1, "auipc");
    run(32'h0080_006F, 1'b1, 32'h0000_0008, 3'd5, 1'b1, "jal_pos");
    run(32'hFFDF_F06F, 1'b1, 32'hFFFF_FFFC, 3'd5, 1'b1, "jal_neg");
    run(32'h0010_006F, 1'b1, 32'h0000_0800, 3'd5, 1'b1, "jal_b11");

    run(32'h0020_81B3, 1'b1, 32'h0, 3'd0, 1'b0, "rtype");
    run(32'hFFFF_F00F, 1'b1, 32'h0, 3'd0, 1'b0, "fence");

    run(32'h0010_0093, 1'b1, 32'h0000_0001, 3'd1, 1'b1, "stream_a");
    run(32'h0020_0093, 1'b1, 32'h0000_0002, 3'd1, 1'b1, "stream_b");
    run(32'h0030_0093, 1'b0, 32'h0,         3'd0, 1'b0, "mid_reset");
    run(32'h0040_0093, 1'b1, 32'h0000_0004, 3'd1, 1'b1, "post_reset");
    run(32'h0050_0093, 1'b1, 32'h0000_0005, 3'd1, 1'b1, "post_reset_2");

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
